id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline stage of the 31-instruction pipelined MIPS CPU; sits directly upstream of the ALU.
- Registers the decoded instruction bundle and produces the ALU operand pair and the 6-bit ALU opcode.
- Operand selection is combinational on the registered state: forwarding, immediate extension, shamt/LUI handling.
- Also detects load-use hazards and inserts bubbles into EX.

Parameters:
DATA_W, 32, datapath width; must be 32 to match the ALU
REG_AW, 5, register index width

Ports:
clk  in  1  pipeline clock
rst_n  in  1  reset, asynchronous, active-low
id_valid  in  1  decode slot holds a real instruction
id_pc  in  32  PC of the decoded instruction
id_rs  in  5  source register index 1
id_rt  in  5  source register index 2
id_rd  in  5  destination index, already chosen rt/rd/31
id_rs_data  in  32  register-file read port 1
id_rt_data  in  32  register-file read port 2
id_imm16  in  16  instruction immediate
id_shamt  in  5  instruction shift amount
id_alu_oper  in  6  ALU opcode, from the shared ALU_* constants
id_use_rs  in  1  instruction reads rs
id_use_rt  in  1  instruction reads rt
id_alu_src_imm  in  1  B operand is the extended immediate
id_imm_zext  in  1  zero-extend imm16 (ANDI/ORI/XORI), else sign-extend
id_shift_shamt  in  1  A operand is shamt (SLL/SRL/SRA)
id_shift_var  in  1  A operand is rs[4:0] (SLLV/SRLV/SRAV)
id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1 each  control bits
flush_i  in  1  squash the instruction entering EX (taken branch/jump)
hold_i  in  1  downstream freeze; stage register keeps its contents
exmem_reg_write  in  1  EX/MEM writes a register
exmem_rd  in  5  EX/MEM destination
exmem_result  in  32  EX/MEM ALU result
memwb_reg_write  in  1  MEM/WB writes a register
memwb_rd  in  5  MEM/WB destination
memwb_data  in  32  MEM/WB writeback value
stall_o  out  1  hold PC and IF/ID this cycle
ex_valid  out  1  EX holds a real instruction
ex_pc  out  32  registered PC
alu_a  out  32  ALU operand A
alu_b  out  32  ALU operand B
alu_oper  out  6  ALU opcode
ex_store_data  out  32  forwarded rt value for SW
ex_rd  out  5  destination index
ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1 each  registered control, gated by ex_valid

Behaviour:
- Reset (async, rst_n=0):
  - All registered fields clear to 0; ex_valid=0.
  - alu_oper resets to ALU_ADDU, so alu_a = alu_b = 0.
  - stall_o=0.
- Register update on a clk rising edge, in priority order:
  1. hold_i=1: keep all contents; stall_o is forced 0, because upstream is frozen by hold_i anyway.
  2. flush_i=1: load a bubble (valid=0, all control bits 0, alu_oper=ALU_ADDU).
  3. stall_o=1: load a bubble.
  4. Otherwise load the id_* bundle; if id_valid=0, load with all control bits forced 0.
- Load-use hazard: stall_o=1 iff all of the following hold:
  - ex_valid, ex_mem_read, and ex_rd!=0;
  - (id_use_rs and id_rs==ex_rd) or (id_use_rt and id_rt==ex_rd);
  - id_valid.
- Forwarding on registered rs/rt (applied separately to rs and rt):
  - If exmem_reg_write and exmem_rd!=0 and exmem_rd matches: take exmem_result.
  - Else if memwb_reg_write and memwb_rd!=0 and memwb_rd matches: take memwb_data.
  - Else take the registered register-file data.
  - Register 0 is never forwarded.
- Immediate extension: ext = id_imm_zext ? {16'b0, imm16} : {{16{imm16[15]}}, imm16}.
- Operand A: shift_shamt → {27'b0, shamt}; shift_var → {27'b0, fwd_rs[4:0]}; else fwd_rs.
- Operand B: alu_src_imm → ext, else fwd_rt. LUI uses alu_src_imm with zext; the ALU performs the <<16.
- ex_store_data = fwd_rt, always.
- Latency: one cycle from id_* to EX outputs; forwarding adds no cycles.
- Simultaneous flush_i and stall_o: the bubble is loaded and stall_o is still driven.
- Reset asserted mid-hold clears the stage immediately.

Optional Feature:
FORWARD_EN
- Defined: forwarding as above.
- Undefined:
  - fwd_rs = registered rs data and fwd_rt = registered rt data (no forwarding).
  - stall_o extends to any RAW hazard: match against EX (ex_valid, ex_reg_write, ex_rd!=0) or against EX/MEM (exmem_reg_write, exmem_rd!=0).
  - MEM/WB is covered by register-file write-before-read.

Decomposition:
- Shared macro header holds the ALU_* 6-bit opcode constants, plus the REG_ZERO index.
- One sub-module, fwd_unit: combinational rs/rt forwarding select, instantiated twice.
- The hazard compare stays inline.

Test Plan:
- ADDI $2,$1,-1 with rs_data=5 → next cycle alu_a=5, alu_b=0xFFFFFFFF, alu_oper=ALU_ADDI.
- ORI with imm16=0x8000 → alu_b=0x00008000. SLL shamt=4 → alu_a=4, alu_b=rt value.
- EX/MEM rd=3 result=0x11 and MEM/WB rd=3 data=0x22, EX reads $3 → alu_a=0x11. Repeat with rd=0 → register-file data is used.
- LW $4 in EX, ID ADD uses $4 → stall_o=1 for exactly one cycle, next EX is a bubble with ex_reg_write=0.
- flush_i pulse with a valid ID instruction → ex_valid=0. hold_i=1 for 3 cycles → outputs unchanged and stall_o=0.
- rst_n low mid-stream, asynchronously between clock edges → ex_valid and all outputs 0 immediately.
- FORWARD_EN undefined: back-to-back ADD RAW → stall_o=1 for two cycles.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX stage: ALU opcode constants, the
// register-zero index, the registered EX bundle and a few small helpers.
package id_ex_stage_pkg;

  localparam int XLEN   = 32;
  localparam int RIDX_W = 5;

  localparam logic [RIDX_W-1:0] REG_ZERO = 5'd0;

  // 6-bit ALU opcodes shared with the ALU
  localparam logic [5:0] ALU_ADDU  = 6'h00;
  localparam logic [5:0] ALU_ADD   = 6'h01;
  localparam logic [5:0] ALU_SUB   = 6'h02;
  localparam logic [5:0] ALU_SUBU  = 6'h03;
  localparam logic [5:0] ALU_AND   = 6'h04;
  localparam logic [5:0] ALU_OR    = 6'h05;
  localparam logic [5:0] ALU_XOR   = 6'h06;
  localparam logic [5:0] ALU_NOR   = 6'h07;
  localparam logic [5:0] ALU_SLT   = 6'h08;
  localparam logic [5:0] ALU_SLTU  = 6'h09;
  localparam logic [5:0] ALU_SLL   = 6'h0A;
  localparam logic [5:0] ALU_SRL   = 6'h0B;
  localparam logic [5:0] ALU_SRA   = 6'h0C;
  localparam logic [5:0] ALU_SLLV  = 6'h0D;
  localparam logic [5:0] ALU_SRLV  = 6'h0E;
  localparam logic [5:0] ALU_SRAV  = 6'h0F;
  localparam logic [5:0] ALU_ADDI  = 6'h10;
  localparam logic [5:0] ALU_ADDIU = 6'h11;
  localparam logic [5:0] ALU_ANDI  = 6'h12;
  localparam logic [5:0] ALU_ORI   = 6'h13;
  localparam logic [5:0] ALU_XORI  = 6'h14;
  localparam logic [5:0] ALU_SLTI  = 6'h15;
  localparam logic [5:0] ALU_SLTIU = 6'h16;
  localparam logic [5:0] ALU_LUI   = 6'h17;

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc;
    logic [RIDX_W-1:0] rs;
    logic [RIDX_W-1:0] rt;
    logic [RIDX_W-1:0] rd;
    logic [XLEN-1:0]   rs_data;
    logic [XLEN-1:0]   rt_data;
    logic [15:0]       imm16;
    logic [RIDX_W-1:0] shamt;
    logic [5:0]        alu_oper;
    logic              alu_src_imm;
    logic              imm_zext;
    logic              shift_shamt;
    logic              shift_var;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
  } ex_bundle_t;

  // A bubble is an all-zero bundle whose opcode is a harmless ADDU of 0+0.
  function automatic ex_bundle_t bubble_bundle();
    ex_bundle_t b;
    b          = '0;
    b.alu_oper = ALU_ADDU;
    return b;
  endfunction

  function automatic logic [XLEN-1:0] extend_imm(input logic [15:0] imm,
                                                  input logic        zext);
    return zext ? {16'b0, imm} : {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/id_ex_stage_fwd_unit.sv
// Operand forwarding select for one source register. EX/MEM has priority
// over MEM/WB; register zero always reads the register-file value.
import id_ex_stage_pkg::*;

module id_ex_stage_fwd_unit #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src_idx_i,
  input  logic [DATA_W-1:0] reg_data_i,
  input  logic              exmem_reg_write_i,
  input  logic [REG_AW-1:0] exmem_rd_i,
  input  logic [DATA_W-1:0] exmem_result_i,
  input  logic              memwb_reg_write_i,
  input  logic [REG_AW-1:0] memwb_rd_i,
  input  logic [DATA_W-1:0] memwb_data_i,
  output logic [DATA_W-1:0] fwd_data_o
);

  logic exmem_hit;
  logic memwb_hit;

  assign exmem_hit = exmem_reg_write_i && (exmem_rd_i != REG_ZERO) &&
                     (exmem_rd_i == src_idx_i);
  assign memwb_hit = memwb_reg_write_i && (memwb_rd_i != REG_ZERO) &&
                     (memwb_rd_i == src_idx_i);

  // Newest producer wins
  always_comb begin
    fwd_data_o = reg_data_i;
    if (exmem_hit) begin
      fwd_data_o = exmem_result_i;
    end else if (memwb_hit) begin
      fwd_data_o = memwb_data_i;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: registers the decoded bundle, builds the ALU
// operand pair and detects hazards that need a bubble.
// Build option FORWARD_EN: when defined, EX/MEM and MEM/WB results are
// forwarded and only load-use hazards stall; when undefined there is no
// forwarding and any RAW hazard against EX or EX/MEM stalls.
import id_ex_stage_pkg::*;

module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [15:0]       id_imm16,
  input  logic [REG_AW-1:0] id_shamt,
  input  logic [5:0]        id_alu_oper,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_alu_src_imm,
  input  logic              id_imm_zext,
  input  logic              id_shift_shamt,
  input  logic              id_shift_var,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic              flush_i,
  input  logic              hold_i,
  input  logic              exmem_reg_write,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_reg_write,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_data,
  output logic              stall_o,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_pc,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [5:0]        alu_oper,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg
);

  ex_bundle_t bundle_q, bundle_d;

  logic [DATA_W-1:0] fwd_rs;
  logic [DATA_W-1:0] fwd_rt;
  logic [DATA_W-1:0] imm_ext;

  logic ex_rd_nz;
  logic id_hits_ex;
  logic load_use;
  logic hazard;

  // ---------------------------------------------------------------------
  // Hazard detection against the instruction currently in EX (and, without
  // forwarding, the one in EX/MEM). hold_i masks the stall because the
  // front end is already frozen.
  // ---------------------------------------------------------------------
  assign ex_rd_nz   = (bundle_q.rd != REG_ZERO);
  assign id_hits_ex = (id_use_rs && (id_rs == bundle_q.rd)) ||
                      (id_use_rt && (id_rt == bundle_q.rd));
  assign load_use   = bundle_q.valid && bundle_q.mem_read && ex_rd_nz && id_hits_ex;

`ifdef FORWARD_EN
  assign hazard = load_use;
`else
  logic id_hits_exmem;
  logic raw_ex;
  logic raw_exmem;

  assign id_hits_exmem = (id_use_rs && (id_rs == exmem_rd)) ||
                         (id_use_rt && (id_rt == exmem_rd));
  assign raw_ex        = bundle_q.valid && bundle_q.reg_write && ex_rd_nz && id_hits_ex;
  assign raw_exmem     = exmem_reg_write && (exmem_rd != REG_ZERO) && id_hits_exmem;
  assign hazard        = load_use || raw_ex || raw_exmem;
`endif

  assign stall_o = id_valid && hazard && !hold_i;

  // Next bundle: hold > flush > stall bubble > load from decode
  always_comb begin
    bundle_d = bundle_q;
    if (hold_i) begin
      bundle_d = bundle_q;
    end else if (flush_i || stall_o) begin
      bundle_d = bubble_bundle();
    end else begin
      bundle_d.valid       = id_valid;
      bundle_d.pc          = id_pc;
      bundle_d.rs          = id_rs;
      bundle_d.rt          = id_rt;
      bundle_d.rd          = id_rd;
      bundle_d.rs_data     = id_rs_data;
      bundle_d.rt_data     = id_rt_data;
      bundle_d.imm16       = id_imm16;
      bundle_d.shamt       = id_shamt;
      bundle_d.alu_oper    = id_alu_oper;
      bundle_d.alu_src_imm = id_alu_src_imm;
      bundle_d.imm_zext    = id_imm_zext;
      bundle_d.shift_shamt = id_shift_shamt;
      bundle_d.shift_var   = id_shift_var;
      bundle_d.reg_write   = id_valid && id_reg_write;
      bundle_d.mem_read    = id_valid && id_mem_read;
      bundle_d.mem_write   = id_valid && id_mem_write;
      bundle_d.mem_to_reg  = id_valid && id_mem_to_reg;
    end
  end

  // Stage register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bundle_q <= bubble_bundle();
    end else begin
      bundle_q <= bundle_d;
    end
  end

  // ---------------------------------------------------------------------
  // Operand sources
  // ---------------------------------------------------------------------
`ifdef FORWARD_EN
  id_ex_stage_fwd_unit #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_fwd_rs (
    .src_idx_i         (bundle_q.rs),
    .reg_data_i        (bundle_q.rs_data),
    .exmem_reg_write_i (exmem_reg_write),
    .exmem_rd_i        (exmem_rd),
    .exmem_result_i    (exmem_result),
    .memwb_reg_write_i (memwb_reg_write),
    .memwb_rd_i        (memwb_rd),
    .memwb_data_i      (memwb_data),
    .fwd_data_o        (fwd_rs)
  );

  id_ex_stage_fwd_unit #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_fwd_rt (
    .src_idx_i         (bundle_q.rt),
    .reg_data_i        (bundle_q.rt_data),
    .exmem_reg_write_i (exmem_reg_write),
    .exmem_rd_i        (exmem_rd),
    .exmem_result_i    (exmem_result),
    .memwb_reg_write_i (memwb_reg_write),
    .memwb_rd_i        (memwb_rd),
    .memwb_data_i      (memwb_data),
    .fwd_data_o        (fwd_rt)
  );
`else
  // Without forwarding the stall covers EX and EX/MEM, and MEM/WB is
  // handled by register-file write-before-read, so the result buses and
  // the registered indices are not needed here.
  logic unused_fwd;

  assign fwd_rs     = bundle_q.rs_data;
  assign fwd_rt     = bundle_q.rt_data;
  assign unused_fwd = ^{exmem_result, memwb_reg_write, memwb_rd, memwb_data,
                        bundle_q.rs, bundle_q.rt};
`endif

  assign imm_ext = extend_imm(bundle_q.imm16, bundle_q.imm_zext);

  // ALU operand A: shamt, low bits of rs, or rs itself
  always_comb begin
    alu_a = fwd_rs;
    if (bundle_q.shift_shamt) begin
      alu_a = {{(DATA_W-REG_AW){1'b0}}, bundle_q.shamt};
    end else if (bundle_q.shift_var) begin
      alu_a = {{(DATA_W-REG_AW){1'b0}}, fwd_rs[REG_AW-1:0]};
    end
  end

  // ALU operand B: extended immediate or rt (LUI shift is done by the ALU)
  always_comb begin
    alu_b = fwd_rt;
    if (bundle_q.alu_src_imm) begin
      alu_b = imm_ext;
    end
  end

  assign alu_oper      = bundle_q.alu_oper;
  assign ex_store_data = fwd_rt;
  assign ex_valid      = bundle_q.valid;
  assign ex_pc         = bundle_q.pc;
  assign ex_rd         = bundle_q.rd;
  assign ex_reg_write  = bundle_q.valid && bundle_q.reg_write;
  assign ex_mem_read   = bundle_q.valid && bundle_q.mem_read;
  assign ex_mem_write  = bundle_q.valid && bundle_q.mem_write;
  assign ex_mem_to_reg = bundle_q.valid && bundle_q.mem_to_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage. Expectations follow the FORWARD_EN
// build option of the compiled design.
import id_ex_stage_pkg::*;

module tb_id_ex_stage;

`ifdef FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_rs_data, id_rt_data;
  logic [15:0] id_imm16;
  logic [4:0]  id_shamt;
  logic [5:0]  id_alu_oper;
  logic        id_use_rs, id_use_rt, id_alu_src_imm, id_imm_zext;
  logic        id_shift_shamt, id_shift_var;
  logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic        flush_i, hold_i;
  logic        exmem_reg_write;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_result;
  logic        memwb_reg_write;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_data;
  logic        stall_o, ex_valid;
  logic [31:0] ex_pc, alu_a, alu_b, ex_store_data;
  logic [5:0]  alu_oper;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm16(id_imm16),
    .id_shamt(id_shamt), .id_alu_oper(id_alu_oper), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .id_alu_src_imm(id_alu_src_imm), .id_imm_zext(id_imm_zext),
    .id_shift_shamt(id_shift_shamt), .id_shift_var(id_shift_var),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .flush_i(flush_i), .hold_i(hold_i),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .stall_o(stall_o), .ex_valid(ex_valid), .ex_pc(ex_pc), .alu_a(alu_a), .alu_b(alu_b),
    .alu_oper(alu_oper), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_id();
    id_valid = 0; id_pc = 0; id_rs = 0; id_rt = 0; id_rd = 0;
    id_rs_data = 0; id_rt_data = 0; id_imm16 = 0; id_shamt = 0;
    id_alu_oper = ALU_ADDU; id_use_rs = 0; id_use_rt = 0;
    id_alu_src_imm = 0; id_imm_zext = 0; id_shift_shamt = 0; id_shift_var = 0;
    id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
  endtask

  task automatic clear_fwd();
    exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
    memwb_reg_write = 0; memwb_rd = 0; memwb_data = 0;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %h exp 0", ex_valid); end
    checks++; if (alu_oper !== ALU_ADDU) begin errors++; $display("FAIL reset_oper: got %h exp %h", alu_oper, ALU_ADDU); end
    checks++; if (alu_a !== 32'h0 || alu_b !== 32'h0) begin errors++; $display("FAIL reset_ops: got a=%h b=%h exp 0/0", alu_a, alu_b); end
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall: got %h exp 0", stall_o); end
    checks++; if (ex_pc !== 32'h0 || ex_rd !== 5'd0) begin errors++; $display("FAIL reset_pc_rd: got pc=%h rd=%0d exp 0/0", ex_pc, ex_rd); end
    #9 rst_n = 1'b1;
    tick();
    checks++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0) begin errors++; $display("FAIL idle_after_reset: got v=%h rw=%h exp 0/0", ex_valid, ex_reg_write); end
  endtask

  task automatic test_operands();
    // ADDI $2,$1,-1 with $1=5
    clear_id(); id_valid = 1; id_pc = 32'h100; id_rs = 1; id_rt = 2; id_rd = 2;
    id_rs_data = 5; id_rt_data = 32'hAAAA; id_imm16 = 16'hFFFF; id_use_rs = 1;
    id_alu_src_imm = 1; id_alu_oper = ALU_ADDI; id_reg_write = 1;
    #1;
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL addi_stall: got %h exp 0", stall_o); end
    tick();
    checks++; if (alu_a !== 32'h5) begin errors++; $display("FAIL addi_a: got %h exp 5", alu_a); end
    checks++; if (alu_b !== 32'hFFFFFFFF) begin errors++; $display("FAIL addi_b: got %h exp ffffffff", alu_b); end
    checks++; if (alu_oper !== ALU_ADDI) begin errors++; $display("FAIL addi_oper: got %h exp %h", alu_oper, ALU_ADDI); end
    checks++; if (ex_valid !== 1'b1 || ex_pc !== 32'h100 || ex_rd !== 5'd2) begin errors++; $display("FAIL addi_ctl: got v=%h pc=%h rd=%0d exp 1/100/2", ex_valid, ex_pc, ex_rd); end
    checks++; if (ex_reg_write !== 1'b1 || ex_mem_read !== 1'b0) begin errors++; $display("FAIL addi_rw: got rw=%h mr=%h exp 1/0", ex_reg_write, ex_mem_read); end
    // ORI with imm 0x8000 zero-extended
    clear_id(); id_valid = 1; id_pc = 32'h104; id_rs = 6; id_rt = 7; id_rd = 7;
    id_rs_data = 32'hF0; id_imm16 = 16'h8000; id_imm_zext = 1; id_alu_src_imm = 1;
    id_alu_oper = ALU_ORI; id_reg_write = 1; id_use_rs = 1;
    tick();
    checks++; if (alu_b !== 32'h00008000) begin errors++; $display("FAIL ori_b: got %h exp 00008000", alu_b); end
    checks++; if (alu_a !== 32'hF0 || alu_oper !== ALU_ORI) begin errors++; $display("FAIL ori_a: got a=%h op=%h exp f0/%h", alu_a, alu_oper, ALU_ORI); end
    // SLL by shamt 4, rt=3
    clear_id(); id_valid = 1; id_rt = 8; id_rt_data = 3; id_shamt = 4; id_rd = 9;
    id_rs_data = 32'h77; id_shift_shamt = 1; id_use_rt = 1; id_alu_oper = ALU_SLL; id_reg_write = 1;
    tick();
    checks++; if (alu_a !== 32'h4 || alu_b !== 32'h3) begin errors++; $display("FAIL sll_ops: got a=%h b=%h exp 4/3", alu_a, alu_b); end
    // SLLV takes rs[4:0]
    clear_id(); id_valid = 1; id_rs = 10; id_rs_data = 32'h123; id_rt = 11; id_rt_data = 1;
    id_shift_var = 1; id_use_rs = 1; id_use_rt = 1; id_rd = 12; id_alu_oper = ALU_SLLV; id_reg_write = 1;
    tick();
    checks++; if (alu_a !== 32'h3 || alu_b !== 32'h1) begin errors++; $display("FAIL sllv_ops: got a=%h b=%h exp 3/1", alu_a, alu_b); end
    // SW: store data is rt
    clear_id(); id_valid = 1; id_rs = 13; id_rs_data = 32'h1000; id_rt = 14; id_rt_data = 32'hDEADBEEF;
    id_imm16 = 16'h0010; id_alu_src_imm = 1; id_mem_write = 1; id_use_rs = 1; id_use_rt = 1;
    id_alu_oper = ALU_ADD;
    tick();
    checks++; if (alu_a !== 32'h1000 || alu_b !== 32'h10) begin errors++; $display("FAIL sw_ops: got a=%h b=%h exp 1000/10", alu_a, alu_b); end
    checks++; if (ex_store_data !== 32'hDEADBEEF || ex_mem_write !== 1'b1 || ex_reg_write !== 1'b0) begin errors++; $display("FAIL sw_ctl: got sd=%h mw=%h rw=%h exp deadbeef/1/0", ex_store_data, ex_mem_write, ex_reg_write); end
    // invalid slot with control bits set must not reach EX
    clear_id(); id_valid = 0; id_reg_write = 1; id_mem_write = 1; id_mem_read = 1; id_rd = 15;
    tick();
    checks++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_mem_write !== 1'b0 || ex_mem_read !== 1'b0) begin errors++; $display("FAIL invalid_ctl: got v=%h rw=%h mw=%h mr=%h exp 0/0/0/0", ex_valid, ex_reg_write, ex_mem_write, ex_mem_read); end
  endtask

  task automatic test_forward();
    clear_id(); clear_fwd(); id_valid = 1; id_rs = 3; id_rs_data = 32'h33; id_rt = 3; id_rt_data = 32'h33;
    id_use_rs = 1; id_rd = 16; id_reg_write = 1; id_alu_oper = ALU_ADD;
    tick();
    clear_id();
    exmem_reg_write = 1; exmem_rd = 3; exmem_result = 32'h11;
    memwb_reg_write = 1; memwb_rd = 3; memwb_data = 32'h22;
    #1;
    checks++; if (alu_a !== (FWD ? 32'h11 : 32'h33)) begin errors++; $display("FAIL fwd_exmem_a: got %h exp %h", alu_a, FWD ? 32'h11 : 32'h33); end
    checks++; if (ex_store_data !== (FWD ? 32'h11 : 32'h33)) begin errors++; $display("FAIL fwd_exmem_sd: got %h exp %h", ex_store_data, FWD ? 32'h11 : 32'h33); end
    exmem_reg_write = 0;
    #1;
    checks++; if (alu_a !== (FWD ? 32'h22 : 32'h33)) begin errors++; $display("FAIL fwd_memwb_a: got %h exp %h", alu_a, FWD ? 32'h22 : 32'h33); end
    // register zero is never forwarded
    clear_fwd(); clear_id(); id_valid = 1; id_rs = 0; id_rs_data = 32'h44; id_use_rs = 1; id_rd = 17;
    id_reg_write = 1; id_alu_oper = ALU_ADD;
    tick();
    clear_id();
    exmem_reg_write = 1; exmem_rd = 0; exmem_result = 32'h11;
    memwb_reg_write = 1; memwb_rd = 0; memwb_data = 32'h22;
    #1;
    checks++; if (alu_a !== 32'h44) begin errors++; $display("FAIL fwd_r0: got %h exp 44", alu_a); end
    clear_fwd();
  endtask

  task automatic test_load_use();
    clear_id(); clear_fwd();
    id_valid = 1; id_pc = 32'h200; id_rs = 1; id_rs_data = 32'h100; id_rd = 4; id_imm16 = 4;
    id_alu_src_imm = 1; id_mem_read = 1; id_reg_write = 1; id_mem_to_reg = 1; id_use_rs = 1;
    id_alu_oper = ALU_ADD;
    tick();
    clear_id(); id_valid = 1; id_pc = 32'h204; id_rs = 4; id_rt = 5; id_rd = 6; id_use_rs = 1;
    id_use_rt = 1; id_reg_write = 1; id_alu_oper = ALU_ADD; id_rs_data = 32'h999; id_rt_data = 5;
    #1;
    checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL lu_stall1: got %h exp 1", stall_o); end
    tick();
    checks++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_mem_read !== 1'b0) begin errors++; $display("FAIL lu_bubble: got v=%h rw=%h mr=%h exp 0/0/0", ex_valid, ex_reg_write, ex_mem_read); end
    exmem_reg_write = 1; exmem_rd = 4; exmem_result = 32'h1234;
    #1;
    checks++; if (stall_o !== (FWD ? 1'b0 : 1'b1)) begin errors++; $display("FAIL lu_stall2: got %h exp %h", stall_o, FWD ? 1'b0 : 1'b1); end
`ifndef FORWARD_EN
    tick();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble2: got %h exp 0", ex_valid); end
    exmem_reg_write = 0; memwb_reg_write = 1; memwb_rd = 4; memwb_data = 32'h1234;
    #1;
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL lu_stall3: got %h exp 0", stall_o); end
`endif
    tick();
    checks++; if (ex_valid !== 1'b1 || ex_rd !== 5'd6 || alu_b !== 32'h5) begin errors++; $display("FAIL lu_issue: got v=%h rd=%0d b=%h exp 1/6/5", ex_valid, ex_rd, alu_b); end
    checks++; if (alu_a !== (FWD ? 32'h1234 : 32'h999)) begin errors++; $display("FAIL lu_issue_a: got %h exp %h", alu_a, FWD ? 32'h1234 : 32'h999); end
    // boundaries: LW $0 never stalls; use flags and id_valid gate the compare
    clear_fwd(); clear_id(); id_valid = 1; id_rd = 0; id_mem_read = 1; id_reg_write = 1;
    tick();
    clear_id(); id_valid = 1; id_rs = 0; id_use_rs = 1;
    #1;
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL lu_r0: got %h exp 0", stall_o); end
    clear_id(); id_valid = 1; id_rd = 4; id_mem_read = 1; id_reg_write = 1;
    tick();
    clear_id(); id_valid = 1; id_rs = 4; id_rt = 4;
    #1;
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL lu_nouse: got %h exp 0", stall_o); end
    id_valid = 0; id_use_rs = 1;
    #1;
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL lu_novalid: got %h exp 0", stall_o); end
    id_valid = 1; id_use_rs = 0; id_rs = 0; id_use_rt = 1;
    #1;
    checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL lu_rt: got %h exp 1", stall_o); end
  endtask

  task automatic test_flush();
    // EX still holds LW $4 and ID reads $4 through rt
    flush_i = 1;
    #1;
    checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL flush_stall: got %h exp 1", stall_o); end
    tick();
    checks++; if (ex_valid !== 1'b0 || alu_oper !== ALU_ADDU || ex_mem_read !== 1'b0) begin errors++; $display("FAIL flush_bubble1: got v=%h op=%h mr=%h exp 0/%h/0", ex_valid, alu_oper, ex_mem_read, ALU_ADDU); end
    clear_id(); id_valid = 1; id_rd = 20; id_reg_write = 1; id_alu_oper = ALU_ADD;
    tick();
    checks++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0) begin errors++; $display("FAIL flush_bubble2: got v=%h rw=%h exp 0/0", ex_valid, ex_reg_write); end
    flush_i = 0;
  endtask

  task automatic test_hold();
    clear_id(); id_valid = 1; id_pc = 32'h300; id_rd = 7; id_mem_read = 1; id_reg_write = 1;
    id_rs = 1; id_rs_data = 32'h50; id_imm16 = 8; id_alu_src_imm = 1; id_alu_oper = ALU_ADD; id_use_rs = 1;
    tick();
    clear_id(); id_valid = 1; id_rs = 7; id_use_rs = 1; id_rd = 21; id_pc = 32'h304; id_alu_oper = ALU_SUB;
    hold_i = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL hold_stall[%0d]: got %h exp 0", i, stall_o); end
      tick();
      checks++; if (ex_pc !== 32'h300 || ex_rd !== 5'd7 || alu_a !== 32'h50 || alu_b !== 32'h8 || ex_mem_read !== 1'b1 || alu_oper !== ALU_ADD) begin errors++; $display("FAIL hold_keep[%0d]: got pc=%h rd=%0d a=%h b=%h mr=%h op=%h exp 300/7/50/8/1/%h", i, ex_pc, ex_rd, alu_a, alu_b, ex_mem_read, alu_oper, ALU_ADD); end
    end
    hold_i = 0;
    #1;
    checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL hold_release: got %h exp 1", stall_o); end
  endtask

  task automatic test_async_reset();
    hold_i = 1;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ex_valid !== 1'b0 || ex_pc !== 32'h0 || ex_rd !== 5'd0 || ex_mem_read !== 1'b0 || ex_reg_write !== 1'b0) begin errors++; $display("FAIL areset_ctl: got v=%h pc=%h rd=%0d mr=%h rw=%h exp all 0", ex_valid, ex_pc, ex_rd, ex_mem_read, ex_reg_write); end
    checks++; if (alu_a !== 32'h0 || alu_b !== 32'h0 || alu_oper !== ALU_ADDU || stall_o !== 1'b0) begin errors++; $display("FAIL areset_ops: got a=%h b=%h op=%h st=%h exp 0/0/%h/0", alu_a, alu_b, alu_oper, stall_o, ALU_ADDU); end
    #2 rst_n = 1'b1;
    hold_i = 0;
    clear_id();
  endtask

  task automatic test_back_to_back();
    int stall_cnt;
    clear_id(); clear_fwd();
    id_valid = 1; id_rs = 1; id_rt = 2; id_rd = 5; id_use_rs = 1; id_use_rt = 1;
    id_reg_write = 1; id_alu_oper = ALU_ADD;
    tick();
    clear_id(); id_valid = 1; id_rs = 5; id_rt = 1; id_rd = 6; id_use_rs = 1; id_use_rt = 1;
    id_reg_write = 1; id_alu_oper = ALU_ADD;
    #1;
    stall_cnt = 0;
    for (int c = 0; c < 6 && stall_o; c++) begin
      stall_cnt++;
      tick();
      if (c == 0) begin
        exmem_reg_write = 1; exmem_rd = 5; exmem_result = 32'h55;
      end else begin
        exmem_reg_write = 0; memwb_reg_write = 1; memwb_rd = 5; memwb_data = 32'h55;
      end
      #1;
    end
    checks++; if (stall_cnt !== (FWD ? 0 : 2)) begin errors++; $display("FAIL raw_stall_cycles: got %0d exp %0d", stall_cnt, FWD ? 0 : 2); end
    tick();
    checks++; if (ex_valid !== 1'b1 || ex_rd !== 5'd6) begin errors++; $display("FAIL raw_issue: got v=%h rd=%0d exp 1/6", ex_valid, ex_rd); end
    clear_id(); clear_fwd();
  endtask

  initial begin
    rst_n = 1'b0; flush_i = 0; hold_i = 0;
    clear_id(); clear_fwd();
    test_reset();
    test_operands();
    test_forward();
    test_load_use();
    test_flush();
    test_hold();
    test_async_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
